// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris core.
//   GRID_ROWS / GRID_COLS / HIDDEN_ROWS : playfield geometry (row 0 is the top)
//   grid_t                              : packed playfield, one COLS-bit word per row
//   line_clear_state_t                  : pass sequencing for the line compactor
//   score_weight()                      : points awarded for rows cleared in one pass
package tetris_pkg;

  localparam int GRID_ROWS   = 22;
  localparam int GRID_COLS   = 10;
  localparam int HIDDEN_ROWS = 2;

  typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } line_clear_state_t;

  localparam logic [3:0] SCORE_WT_1 = 4'd1;
  localparam logic [3:0] SCORE_WT_2 = 4'd3;
  localparam logic [3:0] SCORE_WT_3 = 4'd5;
  localparam logic [3:0] SCORE_WT_4 = 4'd8;

  // Four or more rows in one pass all earn the top weight.
  function automatic logic [3:0] score_weight(input logic [4:0] lines);
    logic [3:0] wt;
    case (lines)
      5'd0:    wt = 4'd0;
      5'd1:    wt = SCORE_WT_1;
      5'd2:    wt = SCORE_WT_2;
      5'd3:    wt = SCORE_WT_3;
      default: wt = SCORE_WT_4;
    endcase
    return wt;
  endfunction

endpackage

// File: rtl/score_accum.sv
// Saturating cumulative score.
//   clk      : system clock
//   reset    : asynchronous, active-low; clears the score
//   i_en     : one-cycle pulse adding the weight of i_lines
//   i_lines  : rows cleared in the pass just finished
//   o_score  : running score, sticks at all-ones instead of wrapping
module score_accum
  import tetris_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic [4:0]         i_lines,
  output logic [SCORE_W-1:0] o_score
);

  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W:0]   w_wt;
  logic [SCORE_W:0]   w_sum;

  // One spare bit on the sum exposes the carry used for saturation.
  assign w_wt  = (SCORE_W+1)'(score_weight(i_lines));
  assign w_sum = {1'b0, r_score} + w_wt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_score <= '0;
    end else if (i_en) begin
      r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
    end
  end

  assign o_score = r_score;

endmodule

// File: rtl/line_clear.sv
// Post-landing grid compactor: removes every full row of the merged grid and
// drops the rows above it, one row per cycle from the bottom up.
//   clk, reset : clock; asynchronous active-low reset
//   start      : pass request, honoured only while idle
//   grid_i     : merged grid, captured on the accepting edge
//   busy       : pass in progress (acceptance through the done cycle)
//   done       : one-cycle pulse, results valid while high
//   grid_o     : compacted grid, held until the next pass completes
//   lines_o    : full rows removed in the last pass
//   score_o    : cumulative saturating score
//   top_out_o  : any spawn-zone row of grid_o is occupied
module line_clear
  import tetris_pkg::line_clear_state_t, tetris_pkg::IDLE, tetris_pkg::SCAN, tetris_pkg::DONE;
#(
  parameter int ROWS        = tetris_pkg::GRID_ROWS,
  parameter int COLS        = tetris_pkg::GRID_COLS,
  parameter int HIDDEN_ROWS = tetris_pkg::HIDDEN_ROWS,
  parameter int SCORE_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ROWS-1:0][COLS-1:0] grid_i,
  output logic                      busy,
  output logic                      done,
  output logic [ROWS-1:0][COLS-1:0] grid_o,
  output logic [4:0]                lines_o,
  output logic [SCORE_W-1:0]        score_o,
  output logic                      top_out_o
);

  localparam int PTR_W = $clog2(ROWS);

  line_clear_state_t r_state, w_state_nxt;

  logic [ROWS-1:0][COLS-1:0] r_src, r_dst, r_grid;
  logic [PTR_W-1:0]          r_rd, r_wr;
  logic [4:0]                r_cnt, r_lines;
  logic                      r_top;

  logic [COLS-1:0]           w_row;
  logic                      w_full;
  logic [ROWS-1:0][COLS-1:0] w_dst_nxt;
  logic [4:0]                w_cnt_nxt;
  logic                      w_top;
  logic                      w_last;

  // Effect of the current SCAN step; on the row-0 step these are the final results.
  always_comb begin
    w_row     = r_src[r_rd];
    w_full    = &w_row;
    w_dst_nxt = r_dst;
    w_cnt_nxt = r_cnt;
    if (w_full) begin
      w_cnt_nxt = r_cnt + 5'd1;
    end else begin
      w_dst_nxt[r_wr] = w_row;
    end
  end

  assign w_top  = |w_dst_nxt[HIDDEN_ROWS-1:0];
  assign w_last = (r_state == SCAN) && (r_rd == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (r_rd == '0) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pointers wrap after the row-0 step; they are reloaded before the next use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_grid  <= '0;
      r_lines <= '0;
      r_top   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_src <= grid_i;
      r_dst <= '0;
      r_rd  <= PTR_W'(ROWS-1);
      r_wr  <= PTR_W'(ROWS-1);
      r_cnt <= '0;
    end else if (r_state == SCAN) begin
      r_dst <= w_dst_nxt;
      r_cnt <= w_cnt_nxt;
      r_rd  <= r_rd - 1'b1;
      if (!w_full) r_wr <= r_wr - 1'b1;
      if (w_last) begin
        r_grid  <= w_dst_nxt;
        r_lines <= w_cnt_nxt;
        r_top   <= w_top;
      end
    end
  end

  score_accum #(
    .SCORE_W (SCORE_W)
  ) u_score (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_last),
    .i_lines (w_cnt_nxt),
    .o_score (score_o)
  );

  assign grid_o    = r_grid;
  assign lines_o   = r_lines;
  assign top_out_o = r_top;

endmodule

// File: tb/tb_line_clear.sv
`timescale 1ns/1ps
module tb_line_clear;

  localparam int ROWS = 22;
  typedef tetris_pkg::grid_t grid_t;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  grid_t grid_i = '0;

  logic busy, done, top_out_o;
  grid_t grid_o;
  logic [4:0] lines_o;
  logic [15:0] score_o;

  // Narrow-score instance: shares stimulus, exercises saturation quickly.
  logic s_busy, s_done, s_top;
  grid_t s_grid;
  logic [4:0] s_lines;
  logic [3:0] s_score;

  int checks = 0, errors = 0;
  int m_score = 0, m_score_s = 0;

  always #5 clk = ~clk;

  line_clear #(.SCORE_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .grid_i(grid_i), .busy(busy), .done(done),
    .grid_o(grid_o), .lines_o(lines_o), .score_o(score_o), .top_out_o(top_out_o));

  line_clear #(.SCORE_W(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .grid_i(grid_i), .busy(s_busy), .done(s_done),
    .grid_o(s_grid), .lines_o(s_lines), .score_o(s_score), .top_out_o(s_top));

  // ---------------- reference model ----------------
  function automatic int m_lines(input grid_t g);
    int n = 0;
    for (int r = 0; r < ROWS; r++) if (g[r] == 10'h3FF) n++;
    return n;
  endfunction

  // Keep the non-full rows in top-to-bottom order and stack them on the floor.
  function automatic grid_t m_compact(input grid_t g);
    logic [9:0] kept[$];
    grid_t o = '0;
    for (int r = 0; r < ROWS; r++) if (g[r] != 10'h3FF) kept.push_back(g[r]);
    for (int i = 0; i < kept.size(); i++) o[ROWS - kept.size() + i] = kept[i];
    return o;
  endfunction

  function automatic logic m_top(input grid_t g);
    return (g[0] != 10'h000) || (g[1] != 10'h000);
  endfunction

  function automatic int m_add(input int s, input int n, input int w);
    int wt, mx, v;
    wt = (n == 0) ? 0 : (n == 1) ? 1 : (n == 2) ? 3 : (n == 3) ? 5 : 8;
    mx = (1 << w) - 1;
    v  = s + wt;
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- stimulus ----------------
  // Runs one pass; lat = edges from acceptance to done (-1 if it never came).
  task automatic do_pass(input grid_t g, output int lat, output logic busy0);
    @(posedge clk); #1; grid_i = g; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; grid_i = ~g;
    busy0 = busy;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    if (lat > 0) begin
      m_score   = m_add(m_score, m_lines(g), 16);
      m_score_s = m_add(m_score_s, m_lines(g), 4);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (grid_o !== '0) begin errors++; $display("FAIL reset_grid: got %h want 0", grid_o); end
    checks++; if (lines_o !== 5'd0) begin errors++; $display("FAIL reset_lines: got %0d want 0", lines_o); end
    checks++; if (score_o !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score_o); end
    checks++; if (top_out_o !== 1'b0) begin errors++; $display("FAIL reset_top: got %0b want 0", top_out_o); end
  endtask

  task automatic test_empty;
    int lat; logic b0;
    do_pass('0, lat, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL empty_busy: got %0b want 1", b0); end
    checks++; if (lat != 22) begin errors++; $display("FAIL empty_latency: got %0d want 22", lat); end
    checks++; if (grid_o !== '0) begin errors++; $display("FAIL empty_grid: got %h want 0", grid_o); end
    checks++; if (lines_o !== 5'd0) begin errors++; $display("FAIL empty_lines: got %0d want 0", lines_o); end
    checks++; if (score_o !== 16'd0) begin errors++; $display("FAIL empty_score: got %0d want 0", score_o); end
    checks++; if (top_out_o !== 1'b0) begin errors++; $display("FAIL empty_top: got %0b want 0", top_out_o); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_pulse: done %0b busy %0b want 0 0", done, busy); end
  endtask

  task automatic test_single;
    int lat; logic b0; grid_t g = '0;
    g[21] = 10'h3FF; g[20] = 10'h001;
    do_pass(g, lat, b0);
    checks++; if (lat != 22) begin errors++; $display("FAIL single_latency: got %0d want 22", lat); end
    checks++; if (grid_o[21] !== 10'h001 || grid_o[20] !== 10'h000) begin errors++; $display("FAIL single_rows: got %h/%h want 001/000", grid_o[21], grid_o[20]); end
    checks++; if (grid_o !== m_compact(g)) begin errors++; $display("FAIL single_grid: got %h want %h", grid_o, m_compact(g)); end
    checks++; if (lines_o !== 5'd1) begin errors++; $display("FAIL single_lines: got %0d want 1", lines_o); end
    checks++; if (score_o !== 16'(m_score)) begin errors++; $display("FAIL single_score: got %0d want %0d", score_o, m_score); end
  endtask

  task automatic test_tetris;
    int lat; logic b0; grid_t g = '0, e = '0;
    for (int r = 18; r <= 21; r++) g[r] = 10'h3FF;
    g[17] = 10'h155; e[21] = 10'h155;
    for (int p = 0; p < 2; p++) begin
      do_pass(g, lat, b0);
      checks++; if (grid_o !== e) begin errors++; $display("FAIL tetris_grid: got %h want %h", grid_o, e); end
      checks++; if (lines_o !== 5'd4) begin errors++; $display("FAIL tetris_lines: got %0d want 4", lines_o); end
      checks++; if (score_o !== 16'(m_score)) begin errors++; $display("FAIL tetris_score: got %0d want %0d", score_o, m_score); end
    end
  endtask

  task automatic test_noncontig;
    int lat; logic b0; int s0; grid_t g = '0;
    g[21] = 10'h3FF; g[19] = 10'h3FF; g[20] = 10'h200; g[18] = 10'h00F;
    s0 = int'(score_o);
    do_pass(g, lat, b0);
    checks++; if (grid_o[21] !== 10'h200 || grid_o[20] !== 10'h00F) begin errors++; $display("FAIL noncontig_rows: got %h/%h want 200/00f", grid_o[21], grid_o[20]); end
    checks++; if (grid_o !== m_compact(g)) begin errors++; $display("FAIL noncontig_grid: got %h want %h", grid_o, m_compact(g)); end
    checks++; if (lines_o !== 5'd2) begin errors++; $display("FAIL noncontig_lines: got %0d want 2", lines_o); end
    checks++; if (int'(score_o) != s0 + 3) begin errors++; $display("FAIL noncontig_score: got %0d want %0d", score_o, s0 + 3); end
  endtask

  task automatic test_ignore_start;
    int lat = -1; grid_t g = '0;
    g[1] = 10'h010;
    @(posedge clk); #1; grid_i = g; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) start = 1'b0;
      if (done) begin lat = k; break; end
      if (k == 4) start = 1'b1;
    end
    if (lat > 0) begin
      m_score = m_add(m_score, 0, 16); m_score_s = m_add(m_score_s, 0, 4);
    end
    checks++; if (lat != 22) begin errors++; $display("FAIL ignore_latency: got %0d want 22", lat); end
    checks++; if (grid_o !== g) begin errors++; $display("FAIL ignore_grid: got %h want %h", grid_o, g); end
    checks++; if (lines_o !== 5'd0) begin errors++; $display("FAIL ignore_lines: got %0d want 0", lines_o); end
    checks++; if (top_out_o !== 1'b1) begin errors++; $display("FAIL ignore_top: got %0b want 1", top_out_o); end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_on_done: busy %0b want 0", busy); end
  endtask

  task automatic test_reset_midscan;
    int lat; logic b0; logic seen = 1'b0; grid_t g = '0;
    g[21] = 10'h3FF; g[15] = 10'h0F0;
    @(posedge clk); #1; grid_i = g; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; reset = 1'b0; #1;
    m_score = 0; m_score_s = 0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: busy %0b done %0b want 0 0", busy, done); end
    checks++; if (grid_o !== '0 || lines_o !== 5'd0 || top_out_o !== 1'b0) begin errors++; $display("FAIL midrst_out: grid %h lines %0d top %0b want 0", grid_o, lines_o, top_out_o); end
    checks++; if (score_o !== 16'd0 || s_score !== 4'd0) begin errors++; $display("FAIL midrst_score: got %0d/%0d want 0/0", score_o, s_score); end
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_nodone: done seen %0b want 0", seen); end
    do_pass(g, lat, b0);
    checks++; if (lat != 22) begin errors++; $display("FAIL midrst_latency: got %0d want 22", lat); end
    checks++; if (score_o !== 16'd1) begin errors++; $display("FAIL midrst_score1: got %0d want 1", score_o); end
    checks++; if (grid_o !== m_compact(g)) begin errors++; $display("FAIL midrst_grid: got %h want %h", grid_o, m_compact(g)); end
  endtask

  task automatic test_saturate;
    int lat; logic b0; grid_t g = '0;
    for (int r = 18; r <= 21; r++) g[r] = 10'h3FF;
    for (int p = 0; p < 3; p++) begin
      do_pass(g, lat, b0);
      checks++; if (s_score !== 4'(m_score_s)) begin errors++; $display("FAIL sat_score: got %0d want %0d", s_score, m_score_s); end
      checks++; if (score_o !== 16'(m_score)) begin errors++; $display("FAIL sat_wide_score: got %0d want %0d", score_o, m_score); end
    end
    checks++; if (s_score !== 4'hF) begin errors++; $display("FAIL sat_ceiling: got %0d want 15", s_score); end
  endtask

  task automatic test_random;
    int lat; logic b0; grid_t g, e;
    for (int it = 0; it < 12; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        case ($urandom_range(0, 3))
          0: g[r] = 10'h3FF;
          1: g[r] = 10'h000;
          default: g[r] = 10'($urandom_range(0, 1023));
        endcase
        if (r < 2 && $urandom_range(0, 2) != 0) g[r] = 10'h000;
      end
      e = m_compact(g);
      do_pass(g, lat, b0);
      checks++; if (lat != 22) begin errors++; $display("FAIL rand_latency: got %0d want 22", lat); end
      checks++; if (grid_o !== e || s_grid !== e) begin errors++; $display("FAIL rand_grid: got %h want %h", grid_o, e); end
      checks++; if (lines_o !== 5'(m_lines(g)) || s_lines !== lines_o) begin errors++; $display("FAIL rand_lines: got %0d/%0d want %0d", lines_o, s_lines, m_lines(g)); end
      checks++; if (top_out_o !== m_top(e) || s_top !== top_out_o) begin errors++; $display("FAIL rand_top: got %0b/%0b want %0b", top_out_o, s_top, m_top(e)); end
      checks++; if (score_o !== 16'(m_score) || s_score !== 4'(m_score_s)) begin errors++; $display("FAIL rand_score: got %0d/%0d want %0d/%0d", score_o, s_score, m_score, m_score_s); end
      checks++; if (s_done !== done || s_busy !== busy) begin errors++; $display("FAIL rand_ctrl: got %0b%0b want %0b%0b", s_done, s_busy, done, busy); end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b1;
    test_empty;
    test_single;
    test_tetris;
    test_noncontig;
    test_ignore_start;
    test_reset_midscan;
    test_saturate;
    test_random;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
